// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register offsets and VECTOR layout shared by the interrupt controller
package irq_ctrl_pkg;
  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_ENABLE = 3'd1;
  localparam logic [2:0] REG_MODE = 3'd2;
  localparam logic [2:0] REG_CLEAR = 3'd3;
  localparam logic [2:0] REG_VECTOR = 3'd4;
  localparam int VECTOR_VALID_BIT = 31;
endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// irq_prio_enc: combinational lowest-index-first encoder; req[N-1:0] -> valid, idx[4:0]
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [4:0]   idx
);
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? 5'(i) : idx;
  end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: dbus interrupt controller; wb_* bus slave (ack/rdt), irq_in[N_IRQ] sources, irq CPU output; VECTOR encoder under IRQ_CTRL_VECTOR_EN
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                ADDR_W = 8,
  parameter logic [ADDR_W-1:0] ADDR = 8'h80,
  parameter int                N_IRQ = 8
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [31:0]      wb_dbus_adr,
  input  logic [31:0]      wb_dbus_dat,
  input  logic             wb_dbus_we,
  input  logic             wb_dbus_cyc,
  output logic             ack,
  output logic [31:0]      rdt,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             irq
);
  logic sel, wr;
  logic [2:0] off;
  logic [N_IRQ-1:0] enable, mode, pending, prev, active, rise, clr, mode_chg, pending_n, wdat;
  logic [31:0] vector, rd;
  logic unused;
  assign unused = ^{wb_dbus_adr[31-ADDR_W:5], wb_dbus_adr[1:0], wb_dbus_dat[31:N_IRQ]};
  assign off = wb_dbus_adr[4:2];
  assign wdat = wb_dbus_dat[N_IRQ-1:0];
  assign sel = wb_dbus_cyc && wb_dbus_adr[31:32-ADDR_W] == ADDR && !ack;
  assign wr = sel && wb_dbus_we;
  assign active = pending & enable;
  assign rise = irq_in & ~prev;
  assign clr = (wr && off == REG_CLEAR) ? wdat : '0;
  assign mode_chg = (wr && off == REG_MODE) ? (wdat ^ mode) : '0;
  // A fresh edge beats a simultaneous CLEAR; a mode flip always drops the channel.
  assign pending_n = ~mode_chg & ((~mode & irq_in) | (mode & (rise | (pending & ~clr))));
  assign rd = off == REG_PENDING ? 32'(pending) :
              off == REG_ENABLE  ? 32'(enable) :
              off == REG_MODE    ? 32'(mode) :
              off == REG_CLEAR   ? 32'(active) :
              off == REG_VECTOR  ? vector : '0;
`ifdef IRQ_CTRL_VECTOR_EN
  logic enc_valid;
  logic [4:0] enc_idx;
  logic [31:0] vector_n;
  irq_prio_enc #(.N(N_IRQ)) u_enc (.req(active), .valid(enc_valid), .idx(enc_idx));
  always_comb begin
    vector_n = '0;
    vector_n[VECTOR_VALID_BIT] = enc_valid;
    vector_n[4:0] = enc_idx;
  end
  always_ff @(posedge wb_clk) vector <= wb_rst ? '0 : vector_n;
`else
  assign vector = '0;
`endif
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack <= 1'b0;
      rdt <= '0;
      enable <= '0;
      mode <= '0;
      pending <= '0;
      prev <= '0;
      irq <= 1'b0;
    end else begin
      ack <= sel;
      rdt <= sel ? rd : '0;
      if (wr && off == REG_ENABLE) enable <= wdat;
      if (wr && off == REG_MODE) mode <= wdat;
      pending <= pending_n;
      prev <= irq_in;
      irq <= |active;
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: randomized and directed checks of irq_ctrl against a cycle-level reference model
module tb_irq_ctrl;
  logic clk = 0, rst = 1, cyc = 0, we = 0;
  logic [31:0] adr = 0, dat = 0;
  logic [7:0] irq_in = 0;
  logic ack, irq;
  logic [31:0] rdt;
  int vectors = 0, miscompares = 0;
  logic [7:0] m_en = 0, m_mode = 0, m_pend = 0, m_prev = 0;
  logic m_ack = 0, m_irq = 0;
  logic [31:0] m_rdt = 0, m_vec = 0;

  irq_ctrl dut (.wb_clk(clk), .wb_rst(rst), .wb_dbus_adr(adr), .wb_dbus_dat(dat),
    .wb_dbus_we(we), .wb_dbus_cyc(cyc), .ack(ack), .rdt(rdt), .irq_in(irq_in), .irq(irq));

  always #5 clk = ~clk;

  task automatic tick();
    logic sel, nirq;
    logic [2:0] o;
    logic [7:0] np, ne, nm, en_pend;
    logic [31:0] rv, nv;
    sel = cyc && adr[31:24] == 8'h80 && !m_ack;
    o = adr[4:2];
    en_pend = m_pend & m_en;
    case (o)
      3'd0: rv = {24'b0, m_pend};
      3'd1: rv = {24'b0, m_en};
      3'd2: rv = {24'b0, m_mode};
      3'd3: rv = {24'b0, en_pend};
      3'd4: rv = m_vec;
      default: rv = 0;
    endcase
    ne = (sel && we && o == 1) ? dat[7:0] : m_en;
    nm = (sel && we && o == 2) ? dat[7:0] : m_mode;
    for (int i = 0; i < 8; i++) begin
      if (sel && we && o == 2 && dat[i] != m_mode[i]) np[i] = 0;
      else if (!m_mode[i]) np[i] = irq_in[i];
      else if (irq_in[i] && !m_prev[i]) np[i] = 1;
      else if (sel && we && o == 3 && dat[i]) np[i] = 0;
      else np[i] = m_pend[i];
    end
    nirq = en_pend != 0;
    nv = 0;
`ifdef IRQ_CTRL_VECTOR_EN
    for (int i = 7; i >= 0; i--) if (en_pend[i]) nv = 32'h8000_0000 | i;
`endif
    if (rst) begin
      m_en = 0; m_mode = 0; m_pend = 0; m_prev = 0; m_ack = 0; m_irq = 0; m_rdt = 0; m_vec = 0;
    end else begin
      m_en = ne; m_mode = nm; m_pend = np; m_prev = irq_in; m_ack = sel;
      m_rdt = sel ? rv : 0; m_irq = nirq; m_vec = nv;
    end
    @(posedge clk); #1;
    vectors += 3;
    if (ack !== m_ack) begin miscompares++; $display("FAIL ack t=%0t got %b exp %b", $time, ack, m_ack); end
    if (rdt !== m_rdt) begin miscompares++; $display("FAIL rdt t=%0t got %h exp %h", $time, rdt, m_rdt); end
    if (irq !== m_irq) begin miscompares++; $display("FAIL irq t=%0t got %b exp %b", $time, irq, m_irq); end
  endtask

  task automatic access(input logic w, input logic [2:0] o, input logic [31:0] d, input logic bad, output logic [31:0] rd);
    cyc = 1; we = w; dat = d;
    adr = {bad ? 8'h40 : 8'h80, 19'b0, o, 2'b0};
    tick();
    rd = rdt;
    vectors++;
    if (ack !== !bad) begin miscompares++; $display("FAIL ack_pulse got %b exp %b", ack, !bad); end
    cyc = 0; we = 0;
    tick();
    vectors++;
    if (ack !== 0) begin miscompares++; $display("FAIL ack_drop got %b exp 0", ack); end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1; tick(); tick(); rst = 0;
    for (int o = 0; o < 8; o++) begin
      access(0, 3'(o), 0, 0, rd);
      vectors += 2;
      if (rd !== 0) begin miscompares++; $display("FAIL reset_read off=%0d got %h exp 0", o, rd); end
      if (irq !== 0) begin miscompares++; $display("FAIL reset_irq got %b exp 0", irq); end
    end
  endtask

  task automatic test_level();
    logic [31:0] rd;
    access(1, 1, 32'h01, 0, rd);
    irq_in = 8'h01; tick();
    vectors++;
    if (irq !== 0) begin miscompares++; $display("FAIL level_lag got %b exp 0", irq); end
    tick();
    vectors++;
    if (irq !== 1) begin miscompares++; $display("FAIL level_rise got %b exp 1", irq); end
    irq_in = 0; tick(); tick();
    vectors++;
    if (irq !== 0) begin miscompares++; $display("FAIL level_fall got %b exp 0", irq); end
  endtask

  task automatic test_edge();
    logic [31:0] rd;
    access(1, 2, 32'h02, 0, rd);
    access(1, 1, 32'h02, 0, rd);
    irq_in = 8'h02; tick(); irq_in = 0; tick(); tick();
    access(0, 0, 0, 0, rd);
    vectors += 2;
    if (rd !== 32'h02) begin miscompares++; $display("FAIL edge_pending got %h exp 2", rd); end
    if (irq !== 1) begin miscompares++; $display("FAIL edge_irq got %b exp 1", irq); end
    access(1, 3, 32'h02, 0, rd);
    access(0, 0, 0, 0, rd);
    vectors += 2;
    if (rd !== 0) begin miscompares++; $display("FAIL edge_clear got %h exp 0", rd); end
    if (irq !== 0) begin miscompares++; $display("FAIL edge_clear_irq got %b exp 0", irq); end
  endtask

  task automatic test_clear_vs_edge();
    logic [31:0] rd;
    irq_in = 8'h02;
    access(1, 3, 32'h02, 0, rd);
    irq_in = 0;
    access(0, 0, 0, 0, rd);
    vectors++;
    if (rd !== 32'h02) begin miscompares++; $display("FAIL clear_vs_edge got %h exp 2", rd); end
    irq_in = 8'h02; tick(); tick(); tick();
    access(1, 3, 32'h02, 0, rd);
    access(0, 0, 0, 0, rd);
    vectors++;
    if (rd !== 0) begin miscompares++; $display("FAIL held_no_rearm got %h exp 0", rd); end
    irq_in = 0; tick();
  endtask

  task automatic test_vector();
    logic [31:0] rd, e1, e2;
`ifdef IRQ_CTRL_VECTOR_EN
    e1 = 32'h8000_0002; e2 = 32'h8000_0005;
`else
    e1 = 0; e2 = 0;
`endif
    access(1, 2, 32'h26, 0, rd);
    access(1, 1, 32'h24, 0, rd);
    irq_in = 8'h24; tick(); irq_in = 0; tick(); tick();
    access(0, 4, 0, 0, rd);
    vectors++;
    if (rd !== e1) begin miscompares++; $display("FAIL vector_first got %h exp %h", rd, e1); end
    access(1, 3, 32'h04, 0, rd);
    access(0, 4, 0, 0, rd);
    vectors++;
    if (rd !== e2) begin miscompares++; $display("FAIL vector_second got %h exp %h", rd, e2); end
  endtask

  task automatic test_bad_addr();
    logic [31:0] rd;
    access(1, 1, 32'h00, 1, rd);
    vectors++;
    if (rd !== 0) begin miscompares++; $display("FAIL bad_addr_rdt got %h exp 0", rd); end
    access(0, 1, 0, 0, rd);
    vectors++;
    if (rd !== 32'h24) begin miscompares++; $display("FAIL bad_addr_state got %h exp 24", rd); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd;
    cyc = 1; we = 1; dat = 32'hff; adr = 32'h8000_0004; rst = 1;
    tick();
    vectors++;
    if (ack !== 0 || rdt !== 0) begin miscompares++; $display("FAIL rst_mid got ack=%b rdt=%h exp 0", ack, rdt); end
    cyc = 0; we = 0; rst = 0; tick();
    access(0, 1, 0, 0, rd);
    vectors++;
    if (rd !== 0) begin miscompares++; $display("FAIL rst_mid_lost got %h exp 0", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    for (int n = 0; n < 600; n++) begin
      irq_in = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 2) == 0)
        access($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) == 0, rd);
      else tick();
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_clear_vs_edge();
    test_vector();
    test_bad_addr();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
